// File: rtl/proc_pkg.sv
// Shared definitions for the mv/mvi/add/sub processor and its program sequencer:
// opcode encodings, sequencer FSM states and the default word width.
package proc_pkg;

    localparam int DATAWIDTH_DEFAULT = 6;

    localparam logic [1:0] OP_MV  = 2'b00;
    localparam logic [1:0] OP_MVI = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DATA  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_END   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/prog_ram.sv
// Program store: register array with a synchronous write port and a
// combinational read port. Contents are never reset.
module prog_ram
    import proc_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEFAULT,
    parameter int ADDR_W    = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [DATAWIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [DATAWIDTH-1:0] rdata
);

    logic [DATAWIDTH-1:0] mem [2**ADDR_W];

    // Write port: one word per cycle when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_seq.sv
// Program sequencer: fetches words from prog_ram and hands them to the
// processor one instruction at a time, supplying the immediate for mvi,
// waiting for Done, and flagging a lost handshake through a watchdog.
module prog_seq
    import proc_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEFAULT,
    parameter int ADDR_W    = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 ProgWe,
    input  logic [ADDR_W-1:0]    ProgAddr,
    input  logic [DATAWIDTH-1:0] ProgData,
    input  logic [ADDR_W:0]      ProgLen,
    input  logic                 Start,
    input  logic                 Stop,
    input  logic                 Done,
    output logic [DATAWIDTH-1:0] DIN,
    output logic                 Run,
    output logic                 Busy,
    output logic [ADDR_W-1:0]    PC,
    output logic                 Finished,
    output logic                 Error
);

    seq_state_t           state;
    // One bit wider than the RAM address so a full-depth program can still
    // reach its length; the low bits give the wrapping RAM address.
    logic [ADDR_W:0]      pc_cnt;
    logic [ADDR_W:0]      pc_inc;
    logic [ADDR_W:0]      len_q;
    logic [1:0]           wd;
    logic                 err_q;
    logic [DATAWIDTH-1:0] ram_word;
    logic [1:0]           opcode;
    logic                 ram_we;

    // The program may only be rewritten while the sequencer is idle
    assign ram_we = ProgWe & (state == ST_IDLE);

    prog_ram #(
        .DATAWIDTH (DATAWIDTH),
        .ADDR_W    (ADDR_W)
    ) u_ram (
        .clk   (Clock),
        .we    (ram_we),
        .waddr (ProgAddr),
        .wdata (ProgData),
        .raddr (pc_cnt[ADDR_W-1:0]),
        .rdata (ram_word)
    );

    assign opcode = ram_word[DATAWIDTH-1 -: 2];
    assign pc_inc = pc_cnt + (ADDR_W+1)'(1);

    // After a completed instruction: end on Stop or when the program is used up
    function automatic seq_state_t continue_to(input logic stop,
                                               input logic [ADDR_W:0] cnt,
                                               input logic [ADDR_W:0] len);
        if (stop || (cnt >= len)) begin
            return ST_END;
        end
        return ST_ISSUE;
    endfunction

    // Sequencer FSM with program counter, length latch and watchdog
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= ST_IDLE;
            pc_cnt <= '0;
            len_q  <= '0;
            wd     <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        len_q  <= ProgLen;
                        pc_cnt <= '0;
                        err_q  <= 1'b0;
                        state  <= (ProgLen == '0) ? ST_END : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Processor latches IR on this edge
                    pc_cnt <= pc_inc;
                    wd     <= '0;
                    state  <= (opcode == OP_MVI) ? ST_DATA : ST_WAIT;
                end
                ST_DATA: begin
                    // Immediate is on DIN; mvi must complete in this cycle
                    pc_cnt <= pc_inc;
                    if (!Done) begin
                        err_q <= 1'b1;
                        state <= ST_END;
                    end else begin
                        state <= continue_to(Stop, pc_inc, len_q);
                    end
                end
                ST_WAIT: begin
                    if (Done) begin
                        state <= continue_to(Stop, pc_cnt, len_q);
                    end else if (wd == 2'd2) begin
                        err_q <= 1'b1;
                        state <= ST_END;
                    end else begin
                        wd <= wd + 2'd1;
                    end
                end
                ST_END: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decodes of registered state; DIN is the RAM word at PC
    assign Run      = (state == ST_ISSUE);
    assign DIN      = ((state == ST_ISSUE) || (state == ST_DATA)) ? ram_word : '0;
    assign Busy     = (state != ST_IDLE);
    assign PC       = pc_cnt[ADDR_W-1:0];
    assign Finished = (state == ST_END) && !err_q;
    assign Error    = err_q;

endmodule
